// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider with independent dividend/divisor widths,
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module divider_seq #(
  parameter int DW = 20,
  parameter int VW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          in_ready,
  input  logic          signed_mode,
  input  logic [DW-1:0] divident,
  input  logic [VW-1:0] divider,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] reminder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  state_t        state;
  logic [DW-1:0] a_in;
  logic [VW-1:0] b_in;
  logic          smode;
  // aq holds the dividend magnitude; quotient bits enter at the LSB as
  // dividend bits leave at the MSB, so after DW steps it is the quotient.
  logic [DW-1:0] aq;
  logic [VW-1:0] b_mag;
  logic [VW-1:0] rem;
  logic          q_neg, r_neg;
  logic          zero_div, ovf;
  logic [CW-1:0] cnt;

  logic          a_neg, b_neg;
  logic [DW-1:0] a_abs;
  logic [VW-1:0] b_abs;
  logic [VW:0]   trial;
  logic          ge;
  logic [VW-1:0] diff;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;

  // Magnitudes fit the unsigned N-bit range, including the most negative value.
  always_comb begin
    a_neg = smode & a_in[DW-1];
    b_neg = smode & b_in[VW-1];
    a_abs = a_neg ? DW'(-a_in) : a_in;
    b_abs = b_neg ? VW'(-b_in) : b_in;
    trial = {rem, aq[DW-1]};
    ge    = (trial >= {1'b0, b_mag});
    // When ge holds the true difference is below b_mag, so the low bits suffice.
    diff  = trial[VW-1:0] - b_mag;
    q_fix = q_neg ? DW'(-aq) : aq;
    r_fix = r_neg ? VW'(-rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      reminder    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      a_in        <= '0;
      b_in        <= '0;
      smode       <= 1'b0;
      aq          <= '0;
      b_mag       <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_in        <= divident;
            b_in        <= divider;
            smode       <= signed_mode;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            in_ready    <= 1'b0;
            state       <= PREP;
          end
        end
        PREP: begin
          aq       <= a_abs;
          b_mag    <= b_abs;
          q_neg    <= a_neg ^ b_neg;
          r_neg    <= a_neg;
          rem      <= '0;
          cnt      <= CW'(DW);
          zero_div <= (b_in == '0);
          ovf      <= a_neg && (a_in == SMIN) && (b_in == '1);
          state    <= (b_in == '0) ? FIX : DIV;
        end
        DIV: begin
          rem <= ge ? diff : trial[VW-1:0];
          aq  <= {aq[DW-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            quotient    <= '1;
            reminder    <= a_in[VW-1:0];
            div_by_zero <= 1'b1;
          end else if (ovf) begin
            quotient    <= SMIN;
            reminder    <= '0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= q_fix;
            reminder    <= r_fix;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
